// File: rtl/vector_to_image_pkg.sv
// Shared widths and FSM encoding for the image row writer and its matching row reader.
package vector_to_image_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned WORDS_PER_ROW = 32;
    localparam int unsigned ROW_W         = WORD_W * WORDS_PER_ROW;
    localparam int unsigned ROWS          = 32;
    localparam int unsigned ADDR_W        = 5;
    localparam int unsigned CNT_W         = $clog2(WORDS_PER_ROW);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/vector_to_image_if.sv
// Word stream into the image writer: source holds in_data until in_valid && in_ready.
interface vector_to_image_if;
    import vector_to_image_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/vector_to_image_row_packer.sv
// Packs consecutive words into one row, word 0 in the LSBs; row includes the word being loaded.
module vector_to_image_row_packer
    import vector_to_image_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [WORD_W-1:0] in_data,
    output logic [ROW_W-1:0]  row,
    output logic              row_full
);

    logic [ROW_W-1:0] row_q;
    logic [CNT_W-1:0] word_cnt;

    // Merge the incoming word so the last transfer of a row is visible in the same cycle.
    always_comb begin
        row = row_q;
        if (load) begin
            row[32'(word_cnt) * WORD_W +: WORD_W] = in_data;
        end
    end

    assign row_full = (word_cnt == CNT_W'(WORDS_PER_ROW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q    <= '0;
            word_cnt <= '0;
        end else if (clear) begin
            word_cnt <= '0;
        end else if (load) begin
            row_q    <= row;
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vector_to_image.sv
// Collects 32 rows of 32 words each and writes them to port A of the image RAM, rows 0..31.
module vector_to_image
    import vector_to_image_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    vector_to_image_if.slave    in_bus,
    output logic                wea,
    output logic [ADDR_W-1:0]   addra,
    output logic [ROW_W-1:0]    dina
);

    state_t            state;
    logic [ADDR_W-1:0] row_cnt;
    logic              xfer;
    logic              pack_clear;
    logic              row_full;
    logic [ROW_W-1:0]  row;

    assign xfer       = in_bus.in_valid && in_bus.in_ready;
    assign pack_clear = ((state == ST_IDLE) && start) || (state == ST_WRITE);

    vector_to_image_row_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (xfer),
        .clear    (pack_clear),
        .in_data  (in_bus.in_data),
        .row      (row),
        .row_full (row_full)
    );

    // in_ready is a registered copy of "in FILL", so it never depends on in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            row_cnt         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            in_bus.in_ready <= 1'b0;
            wea             <= 1'b0;
            addra           <= '0;
            dina            <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state           <= ST_FILL;
                        row_cnt         <= '0;
                        busy            <= 1'b1;
                        in_bus.in_ready <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (xfer && row_full) begin
                        state           <= ST_WRITE;
                        in_bus.in_ready <= 1'b0;
                        wea             <= 1'b1;
                        addra           <= row_cnt;
                        dina            <= row;
                    end
                end
                ST_WRITE: begin
                    wea <= 1'b0;
                    if (row_cnt == ADDR_W'(ROWS - 1)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state           <= ST_FILL;
                        row_cnt         <= row_cnt + ADDR_W'(1);
                        in_bus.in_ready <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
